ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage of the MIPS datapath: owns the PC, fetches from instruction memory
//  over a req/ack handshake and holds the instruction in an instruction register (IR).
//  Drives imm16 (IR[15:0]) straight into the immediate extender.
//  Consumes the extender's imm32 plus branch/jump decisions to compute the next PC.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  NOP_INSTR 32'h0000_0000  IR value on reset and while invalid (sll $0,$0,0)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  imem_req     out  1   fetch request, held high until imem_ack
//  imem_addr    out  32  fetch address = PC, [1:0] always 2'b00
//  imem_ack     in   1   memory has valid imem_rdata this cycle
//  imem_rdata   in   32  fetched instruction word
//  stall        in   1   downstream not ready; hold current instruction
//  branch_taken in   1   conditional branch resolved taken for current instr
//  branch_imm32 in   32  sign-extended offset from extender (word units)
//  jump         in   1   J/JAL for current instr
//  jump_target  in   26  IR[25:0] target field
//  instr        out  32  current instruction (IR)
//  imm16        out  16  IR[15:0], to extender
//  pc_out       out  32  PC of instr
//  pc_plus4     out  32  pc_out + 4 (for JAL link)
//  instr_valid  out  1   instr/pc_out valid for decode
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, PC=RESET_PC, IR=NOP_INSTR, instr_valid=0, imem_req=0.
//  - FSM IDLE -> FETCH (unconditional, 1 cycle after reset release).
//    FETCH: imem_req=1, imem_addr=PC stable until ack. On imem_ack: IR<=imem_rdata,
//    instr_valid<=1, -> ISSUE. imem_ack outside FETCH is ignored.
//    ISSUE: instr_valid=1, IR/PC held. If stall=1 stay (redirect inputs ignored).
//    If stall=0: PC<=next_pc, instr_valid<=0, IR unchanged, -> FETCH.
//  - next_pc (sampled only in ISSUE with stall=0), priority jump > branch > seq:
//    jump: {pc_plus4[31:28], jump_target, 2'b00}; branch: pc_plus4 + (branch_imm32<<2);
//    else pc_plus4. All sums modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000). No delay slot.
//  - Min latency: ack in first FETCH cycle -> instr_valid next cycle; throughput 1 instr / 2 cycles.
//  - imem_req and instr_valid are never high in the same cycle.
//  - Async reset mid-FETCH drops imem_req immediately; the outstanding ack is not captured.
// CONFIGURATION
//  IFETCH_PERF_EN defined: adds ports fetch_cnt out 32 (+1 per accepted ack) and
//  stall_cnt out 32 (+1 per ISSUE cycle with stall=1); both reset to 0 and wrap at 2^32.
//  Not defined: ports and counters absent; no other behavioural change.
// STRUCTURE
//  mips_pkg: fetch state encoding (IDLE/FETCH/ISSUE), NOP_INSTR, default RESET_PC, field slices.
//  Sub-module next_pc_calc (combinational): pc_plus4, branch target, jump target, priority mux.
// TESTING
//  1. Reset release, ack after 0 wait: imem_addr=0x0, IR=0x2008_0005 -> instr_valid=1, imm16=0x0005, pc_out=0.
//  2. Sequential: 3 fetches, ack delayed 3 cycles -> addresses 0x0,0x4,0x8; imem_addr stable while waiting.
//  3. Branch at PC=0x10, imm32=0xFFFF_FFFE -> next fetch 0x0C; imm32=0x0000_0003 -> 0x20.
//  4. Jump at PC=0x9000_0000, target=0x0000_040 -> 0x9000_0100; jump+branch both set -> jump wins.
//  5. Stall=1 for 4 cycles -> IR/pc_out/instr_valid held, redirect ignored until stall=0.
//  6. PC=0xFFFF_FFFC sequential -> wraps to 0x0; async reset mid-FETCH -> imem_req=0 same cycle, PC=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// Module  : mips_pkg
// Brief   : Shared fetch-stage types, reset constants and instruction field helpers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] C_NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [15:0] imm16_of(input logic [31:0] ir);
        return ir[15:0];
    endfunction

    function automatic logic [31:0] jump_pc(input logic [31:0] pc_plus4,
                                            input logic [25:0] target);
        return {pc_plus4[31:28], target, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_unit_next_pc_calc.sv
//------------------------------------------------------------------------------
// Module  : next_pc_calc
// Brief   : Combinational next-PC: jump beats branch beats sequential, mod 2^32.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm32,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] w_branch_pc;
    logic [31:0] w_jump_pc;

    always_comb begin
        pc_plus4    = pc + 32'd4;
        w_branch_pc = pc_plus4 + (branch_imm32 << 2);
        w_jump_pc   = jump_pc(pc_plus4, jump_target);
        if (jump) begin
            next_pc = w_jump_pc;
        end else if (branch_taken) begin
            next_pc = w_branch_pc;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
//------------------------------------------------------------------------------
// Module  : ifetch_unit
// Brief   : MIPS fetch stage: PC, req/ack imem fetch, IR, next-PC redirect.
//           Optional perf counters when IFETCH_PERF_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm32,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] instr,
    output logic [15:0] imm16,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
`ifdef IFETCH_PERF_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        instr_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         valid_q, valid_d;
    logic         req_q, req_d;
    logic [31:0]  w_next_pc;
    logic         w_ack_accept;

    next_pc_calc u_next_pc_calc (
        .pc           (pc_q),
        .branch_taken (branch_taken),
        .branch_imm32 (branch_imm32),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (w_next_pc)
    );

    assign w_ack_accept = (state_q == ST_FETCH) && imem_ack;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Redirect inputs only matter on the cycle the instruction leaves.
                if (!stall) begin
                    pc_d    = w_next_pc;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign instr       = ir_q;
    assign imm16       = imm16_of(ir_q);
    assign pc_out      = pc_q;
    assign instr_valid = valid_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, w_ack_accept};
        stall_cnt_d = stall_cnt_q + {31'd0, (state_q == ST_ISSUE) && stall};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic w_unused_ack;
    assign w_unused_ack = w_ack_accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_ifetch_unit
// Brief   : Scoreboard bench for ifetch_unit (IFETCH_PERF_EN optional).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_imm32;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] instr;
    logic [15:0] imm16;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pc;
    logic [31:0] sb_instr_q[$];
    logic [31:0] sb_pc_q[$];

    ifetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm32 (branch_imm32),
        .jump         (jump),
        .jump_target  (jump_target),
        .instr        (instr),
        .imm16        (imm16),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
`ifdef IFETCH_PERF_EN
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .instr_valid  (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_eq("req_valid_excl", {31'd0, imem_req & instr_valid}, 32'd0);
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br,
                                               input logic [31:0] imm, input logic jmp,
                                               input logic [25:0] tgt);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jmp)     return {p4[31:28], tgt, 2'b00};
        else if (br) return p4 + {imm[29:0], 2'b00};
        else         return p4;
    endfunction

    // Fetch one word after wait_cyc cycles of ack delay, then issue with
    // stall_cyc stall cycles and the given redirect on the release cycle.
    task automatic fetch_issue(input logic [31:0] word, input int wait_cyc, input int stall_cyc,
                               input logic br, input logic [31:0] imm,
                               input logic jmp, input logic [25:0] tgt);
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        int          guard;
        guard = 0;
        while (!imem_req && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("req_seen", {31'd0, imem_req}, 32'd1);
        check_eq("fetch_addr", imem_addr, exp_pc);
        for (int w = 0; w < wait_cyc; w++) begin
            tick();
            check_eq("addr_stable", imem_addr, exp_pc);
            check_eq("req_held", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb_instr_q.push_back(word);
        sb_pc_q.push_back(exp_pc);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_eq("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        if (sb_instr_q.size() != 0) begin
            held_instr = sb_instr_q.pop_front();
            held_pc    = sb_pc_q.pop_front();
            check_eq("instr", instr, held_instr);
            check_eq("pc_out", pc_out, held_pc);
            check_eq("imm16", {16'd0, imm16}, {16'd0, held_instr[15:0]});
            check_eq("pc_plus4", pc_plus4, held_pc + 32'd4);
        end else begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end
        // Redirect inputs toggled during stall must be ignored.
        for (int s = 0; s < stall_cyc; s++) begin
            stall        = 1'b1;
            branch_taken = 1'b1;
            jump         = 1'b1;
            jump_target  = 26'h3FF_FFFF;
            branch_imm32 = 32'h0000_1000;
            tick();
            check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("stall_instr", instr, word);
            check_eq("stall_pc", pc_out, exp_pc);
        end
        stall        = 1'b0;
        branch_taken = br;
        branch_imm32 = imm;
        jump         = jmp;
        jump_target  = tgt;
        exp_pc       = model_next(exp_pc, br, imm, jmp, tgt);
        tick();
        branch_taken = 1'b0;
        jump         = 1'b0;
        branch_imm32 = 32'd0;
        jump_target  = 26'd0;
        check_eq("release_invalid", {31'd0, instr_valid}, 32'd0);
        check_eq("next_addr", imem_addr, exp_pc);
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_imm32 = 32'd0;
        jump         = 1'b0;
        jump_target  = 26'd0;
        exp_pc       = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0000_0000);
        check_eq("rst_pc", pc_out, 32'h0000_0000);
        rst_n = 1'b1;
        tick();

        // Zero-wait fetch of 0x2008_0005 at PC 0.
        fetch_issue(32'h2008_0005, 0, 0, 1'b0, 32'd0, 1'b0, 26'd0);
        check_eq("t1_addr4", imem_addr, 32'h0000_0004);
        // Sequential fetches with 3-cycle ack delay.
        fetch_issue(32'h2009_0001, 3, 0, 1'b0, 32'd0, 1'b0, 26'd0);
        fetch_issue(32'h200A_0002, 3, 0, 1'b0, 32'd0, 1'b0, 26'd0);
        check_eq("t2_addrC", imem_addr, 32'h0000_000C);
        fetch_issue(32'h200B_0003, 1, 0, 1'b0, 32'd0, 1'b0, 26'd0);
        check_eq("t2_addr10", imem_addr, 32'h0000_0010);

        // Branches at 0x10.
        fetch_issue(32'h1000_FFFE, 0, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0);
        check_eq("br_back", imem_addr, 32'h0000_000C);
        fetch_issue(32'h0000_0000, 0, 0, 1'b0, 32'd0, 1'b0, 26'd0);
        fetch_issue(32'h1000_0003, 2, 0, 1'b1, 32'h0000_0003, 1'b0, 26'd0);
        check_eq("br_fwd", imem_addr, 32'h0000_0020);
        fetch_issue(32'h1000_0000, 0, 0, 1'b1, 32'h23FF_FFF7, 1'b0, 26'd0);
        check_eq("br_far", imem_addr, 32'h9000_0000);

        // Jump, then jump+branch together (jump wins), with a 4-cycle stall.
        fetch_issue(32'h0800_0040, 1, 0, 1'b0, 32'd0, 1'b1, 26'h000_0040);
        check_eq("jump", imem_addr, 32'h9000_0100);
        fetch_issue(32'h0800_0080, 0, 4, 1'b1, 32'h0000_0010, 1'b1, 26'h000_0080);
        check_eq("jump_wins", imem_addr, 32'h9000_0200);

        // Wrap from 0xFFFF_FFFC.
        fetch_issue(32'h1000_0000, 0, 0, 1'b1, 32'h1BFF_FF7E, 1'b0, 26'd0);
        check_eq("to_top", imem_addr, 32'hFFFF_FFFC);
        fetch_issue(32'h2000_1234, 0, 0, 1'b0, 32'd0, 1'b0, 26'd0);
        check_eq("wrap", imem_addr, 32'h0000_0000);
        fetch_issue(32'h2000_0004, 0, 0, 1'b0, 32'd0, 1'b0, 26'd0);

        // Async reset while a fetch is pending: ack in same cycle is dropped.
        tick();
        check_eq("pre_rst_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req", {31'd0, imem_req}, 32'd0);
        check_eq("arst_pc", pc_out, 32'h0000_0000);
        tick();
        imem_ack = 1'b0;
        check_eq("arst_instr", instr, 32'h0000_0000);
        check_eq("arst_valid", {31'd0, instr_valid}, 32'd0);
        rst_n  = 1'b1;
        exp_pc = 32'd0;
        tick();
        fetch_issue(32'h2008_0007, 0, 0, 1'b0, 32'd0, 1'b0, 26'd0);

        check_eq("sb_drained", sb_instr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
